// File: rtl/imsic_msi_pkg.sv
// Shared types for the IMSIC MSI writer: FSM states, queued entry layout and
// the AXI-lite request/response structs seen on the master port.
package imsic_msi_pkg;

   localparam logic [63:0] FILE_PAGE   = 64'h1000;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] id;
   } msi_entry_t;

   typedef struct packed {
      logic [63:0] addr;
      logic [2:0]  prot;
   } axi_ax_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
   } axi_w_t;

   typedef struct packed {
      logic [1:0] resp;
   } axi_b_t;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
   } axi_r_t;

   typedef struct packed {
      axi_ax_t aw;
      logic    aw_valid;
      axi_w_t  w;
      logic    w_valid;
      logic    b_ready;
      axi_ax_t ar;
      logic    ar_valid;
      logic    r_ready;
   } axi_lite_req_t;

   typedef struct packed {
      logic   aw_ready;
      logic   w_ready;
      logic   b_valid;
      axi_b_t b;
      logic   ar_ready;
      logic   r_valid;
      axi_r_t r;
   } axi_lite_resp_t;

   // Index width that never collapses to zero bits for a single-entry range.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/imsic_msi_writer_fifo.sv
// Synchronous FIFO for queued MSI entries; pointers carry an extra wrap bit
// so full and empty are distinguished without a separate counter.
module imsic_msi_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             ni_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign o_full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign o_empty = (wptr_q == rptr_q);
   assign o_rdata = mem_q[rptr_q[PW-1:0]];
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + (PW+1)'(1);
      if (do_pop)  rptr_d = rptr_q + (PW+1)'(1);
   end

   always_ff @(posedge i_clk or negedge ni_rst) begin
      if (!ni_rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem_q[wptr_q[PW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/imsic_msi_writer.sv
// Queued MSI injector: validates (imsic, file, id) requests, buffers them and
// issues each as one AXI-lite write to the target file's seteipnum_le register.
module imsic_msi_writer
   import imsic_msi_pkg::*;
#(
   parameter int          NR_SRC                = 30,
   parameter int          NR_IMSICS             = 4,
   parameter int          NR_VS_FILES_PER_IMSIC = 1,
   parameter int          AXI_ADDR_WIDTH        = 64,
   parameter int          AXI_DATA_WIDTH        = 64,
   parameter int          FIFO_DEPTH            = 8,
   parameter logic [63:0] IMSIC_BASE_ADDR       = 64'h2400_0000,
   parameter logic [63:0] IMSIC_STRIDE          = 64'h8000,
   parameter int          CNT_W                 = 16,
   parameter type         axi_req_t             = axi_lite_req_t,
   parameter type         axi_resp_t            = axi_lite_resp_t,
   localparam int         NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
   localparam int         IMSIC_LEN             = clog2_min1(NR_IMSICS),
   localparam int         INTP_FILE_LEN         = clog2_min1(NR_INTP_FILES),
   localparam int         NR_SRC_LEN            = clog2_min1(NR_SRC)
) (
   input  logic                     i_clk,
   input  logic                     ni_rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [IMSIC_LEN-1:0]     i_imsic,
   input  logic [INTP_FILE_LEN-1:0] i_file,
   input  logic [NR_SRC_LEN-1:0]    i_id,
   output axi_req_t                 o_req,
   input  axi_resp_t                i_resp,
   output logic                     o_busy,
   output logic                     o_err,
   output logic [CNT_W-1:0]         o_err_cnt,
   output logic [CNT_W-1:0]         o_drop_cnt
);

   localparam int AW   = AXI_ADDR_WIDTH;
   localparam bit DW64 = (AXI_DATA_WIDTH == 64);

   state_e           state_q, state_d;
   logic             aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
   logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [AW-1:0]    awaddr_q, awaddr_d;
   logic [31:0]      wid_q, wid_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;

   logic             req_ok, push, drop, pop;
   logic             fifo_full, fifo_empty;
   logic [AW-1:0]    req_addr;
   msi_entry_t       push_entry, pop_entry;
   logic [63:0]      wdata;
   logic [7:0]       wstrb;
   logic             unused_resp;

   assign req_ok = (int'(i_imsic) < NR_IMSICS) && (int'(i_file) < NR_INTP_FILES) &&
                   (i_id != '0) && (int'(i_id) < NR_SRC);
   assign o_ready = !fifo_full;
   assign push    = i_valid && o_ready && req_ok;
   assign drop    = i_valid && o_ready && !req_ok;

   assign req_addr = AW'(IMSIC_BASE_ADDR) + AW'(i_imsic) * AW'(IMSIC_STRIDE)
                   + AW'(i_file) * AW'(FILE_PAGE);
   assign push_entry.addr = 64'(req_addr);
   assign push_entry.id   = 32'(i_id);

   imsic_msi_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(msi_entry_t))
   ) u_fifo (
      .i_clk   (i_clk),
      .ni_rst  (ni_rst),
      .i_push  (push),
      .i_wdata (push_entry),
      .i_pop   (pop),
      .o_rdata (pop_entry),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // AW and W complete independently; the done flags let either order work.
   always_comb begin
      state_d    = state_q;
      aw_valid_d = aw_valid_q;
      w_valid_d  = w_valid_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      awaddr_d   = awaddr_q;
      wid_d      = wid_q;
      err_d      = 1'b0;
      err_cnt_d  = err_cnt_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               awaddr_d   = pop_entry.addr[AW-1:0];
               wid_d      = pop_entry.id;
               aw_valid_d = 1'b1;
               w_valid_d  = 1'b1;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               state_d    = ADDR;
            end
         end
         ADDR: begin
            if (aw_valid_q && i_resp.aw_ready) begin
               aw_valid_d = 1'b0;
               aw_done_d  = 1'b1;
            end
            if (w_valid_q && i_resp.w_ready) begin
               w_valid_d = 1'b0;
               w_done_d  = 1'b1;
            end
            if (aw_done_d && w_done_d) state_d = RESP;
         end
         RESP: begin
            if (i_resp.b_valid) begin
               state_d = IDLE;
               if (i_resp.b.resp != RESP_OKAY) begin
                  err_d = 1'b1;
                  if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge i_clk or negedge ni_rst) begin
      if (!ni_rst) begin
         state_q    <= IDLE;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         awaddr_q   <= '0;
         wid_q      <= '0;
         err_q      <= 1'b0;
         err_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         awaddr_q   <= awaddr_d;
         wid_q      <= wid_d;
         err_q      <= err_d;
         err_cnt_q  <= err_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // On a 64-bit bus the seteipnum_le word sits in the lane picked by addr[2].
   assign wdata = DW64 ? {wid_q, wid_q} : {32'h0, wid_q};
   assign wstrb = (DW64 && awaddr_q[2]) ? 8'hF0 : 8'h0F;

   always_comb begin
      o_req          = '0;
      o_req.aw.addr  = 64'(awaddr_q);
      o_req.aw.prot  = 3'b000;
      o_req.aw_valid = aw_valid_q;
      o_req.w.data   = wdata;
      o_req.w.strb   = wstrb;
      o_req.w_valid  = w_valid_q;
      o_req.b_ready  = (state_q == RESP);
   end

   assign unused_resp = ^{i_resp.ar_ready, i_resp.r_valid, i_resp.r};

   assign o_busy     = !fifo_empty || (state_q != IDLE);
   assign o_err      = err_q;
   assign o_err_cnt  = err_cnt_q;
   assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_imsic_msi_writer.sv
// Directed bench for imsic_msi_writer against a small AXI-lite slave with
// programmable AW/W stalls and an injectable SLVERR response.
module tb_imsic_msi_writer;
   import imsic_msi_pkg::*;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           i_valid = 1'b0;
   logic [1:0]     imsic = '0;
   logic [1:0]     file = '0;
   logic [4:0]     id = '0;
   axi_lite_req_t  req;
   axi_lite_resp_t resp = '0;
   logic           o_ready, o_busy, o_err;
   logic [15:0]    err_cnt, drop_cnt;

   always #5 clk = ~clk;

   // Three IMSICs keep an out-of-range index encodable on the 2-bit port.
   imsic_msi_writer #(.NR_IMSICS(3)) dut (
      .i_clk      (clk),
      .ni_rst     (rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_imsic    (imsic),
      .i_file     (file),
      .i_id       (id),
      .o_req      (req),
      .i_resp     (resp),
      .o_busy     (o_busy),
      .o_err      (o_err),
      .o_err_cnt  (err_cnt),
      .o_drop_cnt (drop_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
      end
   endtask

   // Slave model; a handshake is logged at the negedge preceding the posedge that takes it.
   int          aw_stall = 0, w_stall = 0, err_idx = -1;
   int          aw_wait = 0, w_wait = 0, b_cnt = 0, err_pulses = 0, rdy_cycles = 0;
   bit          b_pend = 1'b0;
   logic [63:0] aw_log[$], w_log[$], s_log[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         resp = '0;
         aw_wait = 0;
         w_wait = 0;
         b_pend = 1'b0;
      end else begin
         if (o_err) err_pulses++;
         if (req.b_ready) rdy_cycles++;
         if (b_pend) begin
            resp.b_valid = 1'b0;
            b_pend = 1'b0;
            b_cnt++;
         end else if (!resp.b_valid && aw_log.size() > b_cnt && w_log.size() > b_cnt) begin
            resp.b_valid = 1'b1;
            resp.b.resp = (b_cnt == err_idx) ? RESP_SLVERR : RESP_OKAY;
         end
         if (resp.b_valid && req.b_ready) b_pend = 1'b1;
         resp.aw_ready = 1'b0;
         if (req.aw_valid) begin
            if (aw_wait >= aw_stall) begin
               resp.aw_ready = 1'b1;
               aw_log.push_back(req.aw.addr);
               aw_wait = 0;
            end else aw_wait++;
         end else aw_wait = 0;
         resp.w_ready = 1'b0;
         if (req.w_valid) begin
            if (w_wait >= w_stall) begin
               resp.w_ready = 1'b1;
               w_log.push_back(req.w.data);
               s_log.push_back(64'(req.w.strb));
               w_wait = 0;
            end else w_wait++;
         end else w_wait = 0;
      end
   end

   task automatic send(input logic [1:0] im, input logic [1:0] f, input logic [4:0] d);
      @(negedge clk);
      i_valid = 1'b1;
      imsic = im;
      file = f;
      id = d;
      for (int k = 0; k < 200 && !o_ready; k++) @(negedge clk);
      chk("send_ready", o_ready, 1);
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 2000 && o_busy; k++) @(negedge clk);
      chk(tag, o_busy, 0);
      repeat (2) @(negedge clk);
   endtask

   function automatic logic [63:0] msi_addr(input int im, input int f);
      return 64'h2400_0000 + 64'(im) * 64'h8000 + 64'(f) * 64'h1000;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, acc, first_low, r0, e0;
      repeat (3) @(negedge clk);
      chk("rst_ready", o_ready, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_err", o_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_aw_valid", req.aw_valid, 0);
      chk("rst_w_valid", req.w_valid, 0);
      chk("rst_b_ready", req.b_ready, 0);
      rst_n = 1'b1;

      // Single MSI to IMSIC 1, S file, id 5
      base = aw_log.size();
      send(2'd1, 2'd1, 5'd5);
      chk("t1_aw_n1", req.aw_valid, 0);
      chk("t1_busy", o_busy, 1);
      @(negedge clk);
      chk("t1_aw_n2", req.aw_valid, 1);
      chk("t1_w_n2", req.w_valid, 1);
      wait_idle("t1_idle");
      chk("t1_cnt", aw_log.size() - base, 1);
      chk("t1_addr", aw_log[base], 64'h2400_9000);
      chk("t1_data", w_log[base], 64'h0000_0005_0000_0005);
      chk("t1_strb", s_log[base], 64'h0F);

      // Ten back-to-back requests against a slow awready
      aw_stall = 20;
      base = aw_log.size();
      acc = 0;
      first_low = -1;
      @(negedge clk);
      for (int k = 0; k < 400 && acc < 10; k++) begin
         i_valid = 1'b1;
         imsic = 2'(acc % 3);
         file = 2'((acc / 3) % 3);
         id = 5'(acc + 1);
         if (o_ready) acc++;
         else if (first_low < 0) first_low = acc;
         @(negedge clk);
      end
      i_valid = 1'b0;
      chk("t2_accepted", acc, 10);
      chk("t2_first_low", first_low, 9);
      wait_idle("t2_idle");
      chk("t2_cnt", aw_log.size() - base, 10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t2_addr%0d", i), aw_log[base+i], msi_addr(i % 3, (i / 3) % 3));
         chk($sformatf("t2_data%0d", i), w_log[base+i], {32'(i + 1), 32'(i + 1)});
      end
      aw_stall = 0;

      // wready three cycles ahead of awready
      aw_stall = 3;
      base = aw_log.size();
      r0 = rdy_cycles;
      send(2'd2, 2'd0, 5'd7);
      wait_idle("t3a_idle");
      chk("t3a_aw_cnt", aw_log.size() - base, 1);
      chk("t3a_w_cnt", w_log.size() - base, 1);
      chk("t3a_resp", rdy_cycles > r0, 1);
      chk("t3a_addr", aw_log[base], 64'h2401_0000);

      // awready and wready in the same cycle
      aw_stall = 2;
      w_stall = 2;
      base = aw_log.size();
      r0 = rdy_cycles;
      send(2'd0, 2'd2, 5'd9);
      wait_idle("t3b_idle");
      chk("t3b_aw_cnt", aw_log.size() - base, 1);
      chk("t3b_w_cnt", w_log.size() - base, 1);
      chk("t3b_resp", rdy_cycles > r0, 1);
      chk("t3b_data", w_log[base], 64'h0000_0009_0000_0009);
      aw_stall = 0;
      w_stall = 0;

      // Invalid requests are swallowed and counted
      base = aw_log.size();
      send(2'd1, 2'd0, 5'd0);
      send(2'd1, 2'd0, 5'd30);
      send(2'd1, 2'd3, 5'd4);
      send(2'd3, 2'd0, 5'd4);
      repeat (5) @(negedge clk);
      chk("t4_drop_cnt", drop_cnt, 4);
      chk("t4_no_axi", aw_log.size() - base, 0);
      chk("t4_busy", o_busy, 0);

      // SLVERR on the second of three writes
      base = aw_log.size();
      e0 = err_pulses;
      err_idx = b_cnt + 1;
      send(2'd0, 2'd0, 5'd11);
      send(2'd0, 2'd0, 5'd12);
      send(2'd0, 2'd1, 5'd13);
      wait_idle("t5_idle");
      chk("t5_err_pulses", err_pulses - e0, 1);
      chk("t5_err_cnt", err_cnt, 1);
      chk("t5_cnt", aw_log.size() - base, 3);
      chk("t5_third_addr", aw_log[base+2], 64'h2400_1000);
      chk("t5_third_data", w_log[base+2], 64'h0000_000D_0000_000D);

      // Reset while a write is stuck in ADDR with three entries behind it
      aw_stall = 50;
      for (int i = 0; i < 4; i++) send(2'd2, 2'd1, 5'(20 + i));
      for (int k = 0; k < 50 && !req.aw_valid; k++) @(negedge clk);
      chk("t6_pre_aw", req.aw_valid, 1);
      chk("t6_pre_full_q", o_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_aw_valid", req.aw_valid, 0);
      chk("t6_w_valid", req.w_valid, 0);
      chk("t6_busy", o_busy, 0);
      chk("t6_ready", o_ready, 1);
      chk("t6_err_cnt", err_cnt, 0);
      chk("t6_drop_cnt", drop_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_post_busy", o_busy, 0);
      chk("t6_post_aw", req.aw_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
